// File: rtl/handshake_tx_ctrl_pkg.sv
// Shared types and default parameters for the valid/acknowledge transmit controller.
package handshake_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitAck,
    StRetry,
    StError
  } state_t;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefTimeout  = 64;
  localparam int unsigned DefMaxRetry = 3;

endpackage

// File: rtl/handshake_tx_ctrl_if.sv
// Upstream write port and downstream valid/acknowledge link of the transmit controller.
interface handshake_tx_ctrl_if
  import handshake_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
);

  logic                     validdata;
  logic [DATA_W-1:0]        data_in;
  logic                     acknowledge;
  logic                     ready;
  logic                     tx_req;
  logic [DATA_W-1:0]        tx_data;
  logic                     busy;
  logic                     error;
  logic [$clog2(DEPTH):0]   fifo_count;

  // Stimulus side: feeds words and acknowledges transfers.
  modport master (
    output validdata, data_in, acknowledge,
    input  ready, tx_req, tx_data, busy, error, fifo_count
  );

  // Controller side.
  modport slave (
    input  validdata, data_in, acknowledge,
    output ready, tx_req, tx_data, busy, error, fifo_count
  );

endinterface

// File: rtl/handshake_tx_ctrl_sync_fifo.sv
// Word FIFO with wrapping pointers; a pop frees space for a same-cycle write even when full.
module sync_fifo
  import handshake_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AddrW-1:0]  wr_ptr;
  logic [AddrW-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CntW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd) begin
        count <= count + 1'b1;
      end else if (!do_wr && do_rd) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_tx_ctrl.sv
// Transmit side of a valid/acknowledge link: buffers upstream words, issues each with tx_req,
// retries on acknowledge timeout and latches a sticky error once retries are exhausted.
module handshake_tx_ctrl
  import handshake_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned MAX_RETRY = DefMaxRetry
) (
  input  logic                clk,
  input  logic                rst,
  handshake_tx_ctrl_if.slave  bus
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t              state;
  logic [TimerW-1:0]   timer;
  logic [RetryW-1:0]   retry_cnt;
  logic                tx_req;
  logic [DATA_W-1:0]   tx_data;
  logic                error;

  logic                fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   head;
  logic [CntW-1:0]     count;

  // Pop on an accepted acknowledge, or discard the word whose retries ran out.
  assign fifo_rd = ((state == StWaitAck) && bus.acknowledge) ||
                   ((state == StRetry) && (retry_cnt == RetryW'(MAX_RETRY)));

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.validdata),
    .wr_data (bus.data_in),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      timer     <= '0;
      retry_cnt <= '0;
      tx_req    <= 1'b0;
      tx_data   <= '0;
      error     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (!fifo_empty) state <= StLoad;
        end
        StLoad: begin
          tx_data   <= head;
          timer     <= '0;
          retry_cnt <= '0;
          tx_req    <= 1'b1;
          state     <= StWaitAck;
        end
        StWaitAck: begin
          // Acknowledge takes priority over a timeout landing on the same edge.
          if (bus.acknowledge) begin
            tx_req    <= 1'b0;
            retry_cnt <= '0;
            state     <= StIdle;
          end else if (timer == TimerW'(TIMEOUT - 1)) begin
            tx_req <= 1'b0;
            state  <= StRetry;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StRetry: begin
          if (retry_cnt < RetryW'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            timer     <= '0;
            tx_req    <= 1'b1;
            state     <= StWaitAck;
          end else begin
            error <= 1'b1;
            state <= StError;
          end
        end
        StError: begin
          tx_req <= 1'b0;
          error  <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.ready      = !fifo_full;
  assign bus.tx_req     = tx_req;
  assign bus.tx_data    = tx_data;
  assign bus.error      = error;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// Directed bench for handshake_tx_ctrl: per-cycle vector table plus timeout/retry/reset sequences.
module tb_handshake_tx_ctrl;

  localparam int unsigned DataW    = 8;
  localparam int unsigned Depth    = 4;
  localparam int unsigned Timeout  = 64;
  localparam int unsigned MaxRetry = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  handshake_tx_ctrl_if #(.DATA_W(DataW), .DEPTH(Depth)) bus ();

  handshake_tx_ctrl #(
    .DATA_W    (DataW),
    .DEPTH     (Depth),
    .TIMEOUT   (Timeout),
    .MAX_RETRY (MaxRetry)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vd;
    logic [7:0] din;
    logic       ack;
    logic       rdy;
    logic       req;
    logic [7:0] dat;
    logic       bsy;
    logic       err;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   bad;

  function automatic void add(input logic vd, input logic [7:0] din, input logic ack,
                              input logic rdy, input logic req, input logic [7:0] dat,
                              input logic bsy, input logic err, input logic [2:0] cnt);
    vec_t t;
    t.vd = vd; t.din = din; t.ack = ack;
    t.rdy = rdy; t.req = req; t.dat = dat; t.bsy = bsy; t.err = err; t.cnt = cnt;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic req,
                            input logic [7:0] dat, input logic bsy, input logic err,
                            input logic [2:0] cnt);
    check({tag, ".ready"},      32'(bus.ready),      32'(rdy));
    check({tag, ".tx_req"},     32'(bus.tx_req),     32'(req));
    check({tag, ".tx_data"},    32'(bus.tx_data),    32'(dat));
    check({tag, ".busy"},       32'(bus.busy),       32'(bsy));
    check({tag, ".error"},      32'(bus.error),      32'(err));
    check({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(cnt));
  endtask

  task automatic step(input logic vd, input logic [7:0] din, input logic ack);
    bus.validdata   = vd;
    bus.data_in     = din;
    bus.acknowledge = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs applied before an edge; expected outputs seen just after it.
    // Single word A5, acknowledged in WAIT_ACK.
    add(1, 8'hA5, 0, 1, 0, 8'h00, 1, 0, 1);
    add(0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 8'hA5, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 8'hA5, 1, 0, 1);
    add(0, 8'h00, 1, 1, 0, 8'hA5, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 8'hA5, 0, 0, 0);
    // Five back-to-back writes; the fifth is dropped.
    add(1, 8'h01, 0, 1, 0, 8'hA5, 1, 0, 1);
    add(1, 8'h02, 0, 1, 0, 8'hA5, 1, 0, 2);
    add(1, 8'h03, 0, 1, 1, 8'h01, 1, 0, 3);
    add(1, 8'h04, 0, 0, 1, 8'h01, 1, 0, 4);
    add(1, 8'h05, 0, 0, 1, 8'h01, 1, 0, 4);
    // Each word acknowledged three cycles after tx_req rises.
    add(0, 8'h00, 1, 1, 0, 8'h01, 1, 0, 3);
    add(0, 8'h00, 0, 1, 0, 8'h01, 1, 0, 3);
    add(0, 8'h00, 0, 1, 1, 8'h02, 1, 0, 3);
    add(0, 8'h00, 0, 1, 1, 8'h02, 1, 0, 3);
    add(0, 8'h00, 0, 1, 1, 8'h02, 1, 0, 3);
    add(0, 8'h00, 1, 1, 0, 8'h02, 1, 0, 2);
    add(0, 8'h00, 0, 1, 0, 8'h02, 1, 0, 2);
    add(0, 8'h00, 0, 1, 1, 8'h03, 1, 0, 2);
    add(0, 8'h00, 0, 1, 1, 8'h03, 1, 0, 2);
    add(0, 8'h00, 0, 1, 1, 8'h03, 1, 0, 2);
    add(0, 8'h00, 1, 1, 0, 8'h03, 1, 0, 1);
    add(0, 8'h00, 0, 1, 0, 8'h03, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 8'h04, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 8'h04, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 8'h04, 1, 0, 1);
    add(0, 8'h00, 1, 1, 0, 8'h04, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 8'h04, 0, 0, 0);
    // Fill to full, then write while popping; acks outside WAIT_ACK are ignored.
    add(1, 8'h11, 0, 1, 0, 8'h04, 1, 0, 1);
    add(1, 8'h12, 0, 1, 0, 8'h04, 1, 0, 2);
    add(1, 8'h13, 0, 1, 1, 8'h11, 1, 0, 3);
    add(1, 8'h14, 0, 0, 1, 8'h11, 1, 0, 4);
    add(1, 8'h15, 1, 0, 0, 8'h11, 1, 0, 4);
    add(0, 8'h00, 1, 0, 0, 8'h11, 1, 0, 4);
    add(0, 8'h00, 1, 0, 1, 8'h12, 1, 0, 4);
    add(0, 8'h00, 1, 1, 0, 8'h12, 1, 0, 3);
    add(0, 8'h00, 0, 1, 0, 8'h12, 1, 0, 3);
    add(0, 8'h00, 0, 1, 1, 8'h13, 1, 0, 3);
    add(0, 8'h00, 1, 1, 0, 8'h13, 1, 0, 2);
    add(0, 8'h00, 0, 1, 0, 8'h13, 1, 0, 2);
    add(0, 8'h00, 0, 1, 1, 8'h14, 1, 0, 2);
    add(0, 8'h00, 1, 1, 0, 8'h14, 1, 0, 1);
    add(0, 8'h00, 0, 1, 0, 8'h14, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 8'h15, 1, 0, 1);
    add(0, 8'h00, 1, 1, 0, 8'h15, 0, 0, 0);

    bus.validdata   = 1'b0;
    bus.data_in     = '0;
    bus.acknowledge = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1, 0, 8'h00, 0, 0, 0);
    rst = 1'b0;
    step(0, 8'h00, 0);
    check_outs("idle", 1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vd, vecs[i].din, vecs[i].ack);
      check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].req, vecs[i].dat,
                 vecs[i].bsy, vecs[i].err, vecs[i].cnt);
    end

    // Acknowledge 40 cycles after the write: well inside the timeout window.
    step(1, 8'hA5, 0);
    step(0, 8'h00, 0);
    bad = 0;
    repeat (38) begin
      step(0, 8'h00, 0);
      if (bus.tx_req !== 1'b1 || bus.tx_data !== 8'hA5) bad++;
    end
    check("gap40_hold", 32'(bad), 32'd0);
    step(0, 8'h00, 1);
    check_outs("gap40_ack", 1, 0, 8'hA5, 0, 0, 0);

    // Acknowledge on the exact timeout edge is accepted.
    step(1, 8'h21, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    check_outs("to_rise", 1, 1, 8'h21, 1, 0, 1);
    bad = 0;
    repeat (Timeout - 1) begin
      step(0, 8'h00, 0);
      if (bus.tx_req !== 1'b1) bad++;
    end
    check("to_hold", 32'(bad), 32'd0);
    step(0, 8'h00, 1);
    check_outs("to_ack", 1, 0, 8'h21, 0, 0, 0);
    bad = 0;
    repeat (4) begin
      step(0, 8'h00, 0);
      if (bus.tx_req !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("to_no_retry", 32'(bad), 32'd0);

    // Never acknowledged: 1 + MaxRetry windows with single-cycle gaps, then error.
    step(1, 8'h31, 0);
    step(0, 8'h00, 0);
    for (int w = 0; w <= MaxRetry; w++) begin
      bad = 0;
      repeat (Timeout) begin
        step(0, 8'h00, 0);
        if (bus.tx_req !== 1'b1 || bus.tx_data !== 8'h31) bad++;
      end
      check($sformatf("retry_win%0d", w), 32'(bad), 32'd0);
      step(0, 8'h00, 0);
      check($sformatf("retry_gap%0d", w), 32'(bus.tx_req), 32'd0);
    end
    step(0, 8'h00, 0);
    check_outs("err_enter", 1, 0, 8'h31, 1, 1, 0);
    step(1, 8'h41, 0);
    check_outs("err_accept", 1, 0, 8'h31, 1, 1, 1);
    bad = 0;
    repeat (5) begin
      step(0, 8'h00, 1);
      if (bus.tx_req !== 1'b0 || bus.error !== 1'b1 || bus.fifo_count !== 3'd1) bad++;
    end
    check("err_stuck", 32'(bad), 32'd0);
    step(1, 8'h42, 0);
    step(1, 8'h43, 0);
    step(1, 8'h44, 0);
    step(1, 8'h45, 0);
    check_outs("err_full", 0, 0, 8'h31, 1, 1, 4);

    // Reset clears the sticky error and flushes the FIFO.
    #2 rst = 1'b1;
    #1 check_outs("rst_err", 1, 0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 8'h00, 0);
    check_outs("post_rst", 1, 0, 8'h00, 0, 0, 0);

    // Reset mid WAIT_ACK aborts immediately; the in-flight word is lost.
    step(1, 8'h51, 0);
    step(1, 8'h52, 0);
    step(0, 8'h00, 0);
    check_outs("wait_pre", 1, 1, 8'h51, 1, 0, 2);
    step(0, 8'h00, 0);
    #2 rst = 1'b1;
    #1 check_outs("rst_wait", 1, 0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(0, 8'h00, 0);
    check_outs("after_abort", 1, 0, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
